// File: rtl/vote_collector.sv
// Four-voter ballot collector: synchronizes and debounces the buttons, then gathers one sticky
// vote per voter during a session that ends on close, a full ballot or a timeout.
module vote_collector #(
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       close,
  input  logic [3:0] btn,
  output logic [3:0] votes,
  output logic       votes_valid,
  output logic       busy,
  output logic [2:0] voted_cnt
);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [3:0]  deb_q, deb_d;
  logic [3:0]  deb_dly_q, deb_dly_d;
  logic [3:0]  rise_q, rise_d;
  logic [7:0]  deb_cnt_q [4];
  logic [7:0]  deb_cnt_d [4];
  logic [3:0]  ballot_q, ballot_d;
  logic [3:0]  votes_q, votes_d;
  logic [15:0] timer_q, timer_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      rise_q    <= '0;
      ballot_q  <= '0;
      votes_q   <= '0;
      timer_q   <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      rise_q    <= rise_d;
      ballot_q  <= ballot_d;
      votes_q   <= votes_d;
      timer_q   <= timer_d;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  // Input conditioning runs in every state so a button already held at start is seen as old.
  always_comb begin
    sync1_d   = btn;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    rise_d    = deb_q & ~deb_dly_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == 8'(DEB_CYCLES - 1)) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // A vote landing on the closing edge still reaches the published ballot.
  always_comb begin
    state_d  = state_q;
    ballot_d = ballot_q;
    votes_d  = votes_q;
    timer_d  = timer_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = COLLECT;
          ballot_d = '0;
          timer_d  = '0;
        end
      end
      COLLECT: begin
        ballot_d = ballot_q | rise_q;
        timer_d  = timer_q + 16'd1;
        if (close || (ballot_q == 4'hF) || (timer_q == 16'(TIMEOUT_CYCLES - 1))) begin
          state_d = DONE;
          votes_d = ballot_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign votes       = votes_q;
  assign votes_valid = (state_q == DONE);
  assign busy        = (state_q == COLLECT);
  assign voted_cnt   = {2'b00, ballot_q[0]} + {2'b00, ballot_q[1]}
                     + {2'b00, ballot_q[2]} + {2'b00, ballot_q[3]};

endmodule

// File: tb/tb_vote_collector.sv
// Bench for vote_collector: directed sessions then random traffic, every cycle compared
// against a behavioural model of the voting rules for two timeout settings.
module tb_vote_collector;

  localparam int DEB  = 4;
  localparam int TO_A = 1000;
  localparam int TO_B = 16;

  logic       clk = 1'b0;
  logic       rstN;
  logic       startA, startB, closeIn;
  logic [3:0] btn;
  logic [3:0] votesA, votesB;
  logic       validA, validB, busyA, busyB;
  logic [2:0] cntA, cntB;

  always #5 clk = ~clk;

  vote_collector #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TO_A)) dutA (
    .clk(clk), .rst_n(rstN), .start(startA), .close(closeIn), .btn(btn),
    .votes(votesA), .votes_valid(validA), .busy(busyA), .voted_cnt(cntA)
  );

  vote_collector #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TO_B)) dutB (
    .clk(clk), .rst_n(rstN), .start(startB), .close(closeIn), .btn(btn),
    .votes(votesB), .votes_valid(validB), .busy(busyB), .voted_cnt(cntB)
  );

  int vecCount = 0;
  int errCount = 0;

  // Model: raw button history, debounced level, pending votes, and per-instance session
  // phase (0 idle, 1 collecting, 2 result cycle).
  logic [3:0] rawQ[$];
  logic [3:0] mDeb;
  int         mPend[4];
  int         mPhase[2];
  int         mTimer[2];
  logic [3:0] mBallot[2];
  logic [3:0] mVotes[2];

  function automatic void modelReset();
    rawQ.delete();
    for (int i = 0; i < DEB + 2; i++) rawQ.push_back(4'b0000);
    mDeb = 4'b0000;
    for (int b = 0; b < 4; b++) mPend[b] = 0;
    for (int d = 0; d < 2; d++) begin
      mPhase[d]  = 0;
      mTimer[d]  = 0;
      mBallot[d] = 4'b0000;
      mVotes[d]  = 4'b0000;
    end
  endfunction

  function automatic void modelEdge();
    logic [3:0] voteNow;
    logic [3:0] nb;
    logic       st;
    logic       allOpp;
    int         limit;
    if (!rstN) begin
      modelReset();
      return;
    end
    voteNow = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      if (mPend[b] == 1) voteNow[b] = 1'b1;
      if (mPend[b] > 0) mPend[b] = mPend[b] - 1;
    end
    for (int d = 0; d < 2; d++) begin
      st    = (d == 0) ? startA : startB;
      limit = (d == 0) ? TO_A : TO_B;
      if (mPhase[d] == 0) begin
        if (st) begin
          mPhase[d]  = 1;
          mBallot[d] = 4'b0000;
          mTimer[d]  = 0;
        end
      end else if (mPhase[d] == 1) begin
        nb = mBallot[d] | voteNow;
        if (closeIn || (mBallot[d] == 4'hF) || (mTimer[d] == limit - 1)) begin
          mPhase[d] = 2;
          mVotes[d] = nb;
        end
        mTimer[d]  = mTimer[d] + 1;
        mBallot[d] = nb;
      end else begin
        mPhase[d] = 0;
      end
    end
    rawQ.push_back(btn);
    void'(rawQ.pop_front());
    // A level is accepted after DEB consecutive opposite raw samples, seen two edges late;
    // the resulting vote lands two edges after acceptance.
    for (int b = 0; b < 4; b++) begin
      allOpp = 1'b1;
      for (int j = 0; j < DEB; j++) if (rawQ[j][b] == mDeb[b]) allOpp = 1'b0;
      if (allOpp) begin
        mDeb[b] = ~mDeb[b];
        if (mDeb[b]) mPend[b] = 2;
      end
    end
  endfunction

  task automatic checkOne(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vecCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkOne("votesA", votesA, mVotes[0]);
    checkOne("validA", {3'b000, validA}, {3'b000, (mPhase[0] == 2)});
    checkOne("busyA",  {3'b000, busyA},  {3'b000, (mPhase[0] == 1)});
    checkOne("cntA",   {1'b0, cntA},     4'($countones(mBallot[0])));
    checkOne("votesB", votesB, mVotes[1]);
    checkOne("validB", {3'b000, validB}, {3'b000, (mPhase[1] == 2)});
    checkOne("busyB",  {3'b000, busyB},  {3'b000, (mPhase[1] == 1)});
    checkOne("cntB",   {1'b0, cntB},     4'($countones(mBallot[1])));
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic sA, input logic sB, input logic c,
                               input logic [3:0] b, input int n);
    startA  = sA;
    startB  = sB;
    closeIn = c;
    btn     = b;
    for (int i = 0; i < n; i++) tick();
    startA  = 1'b0;
    startB  = 1'b0;
    closeIn = 1'b0;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    #1;
    modelReset();
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 2);
    rstN = 1'b1;
  endtask

  initial begin
    int waited;
    logic [3:0] rb;
    logic rsA, rsB, rc;
    rstN = 1'b0; startA = 1'b0; startB = 1'b0; closeIn = 1'b0; btn = 4'b0000;
    modelReset();
    #2;
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 2);
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 2);

    // Basic session: voters 0 and 2, then close.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0100, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 8);
    checkOne("basic busy open", {3'b000, busyA}, 4'b0001);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 1);
    checkOne("basic votes", votesA, 4'b0101);
    checkOne("basic valid", {3'b000, validA}, 4'b0001);
    checkOne("basic cnt", {1'b0, cntA}, 4'd2);
    checkOne("basic busy fell", {3'b000, busyA}, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 1);
    checkOne("basic pulse ends", {3'b000, validA}, 4'b0000);
    checkOne("basic votes hold", votesA, 4'b0101);

    // All four vote, session ends without close.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 8);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0011, 8);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0111, 8);
    waited = 0;
    while (!validA && waited < 20) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 1);
      waited++;
    end
    checkOne("allvoted done", {3'b000, validA}, 4'b0001);
    checkOne("allvoted votes", votesA, 4'b1111);
    checkOne("allvoted cnt", {1'b0, cntA}, 4'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 8);

    // Timeout on the 16-cycle instance.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0010, 15);
    checkOne("timeout early", {3'b000, validB}, 4'b0000);
    checkOne("timeout busy", {3'b000, busyB}, 4'b0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0010, 1);
    checkOne("timeout valid", {3'b000, validB}, 4'b0001);
    checkOne("timeout votes", votesB, 4'b0010);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 8);

    // Held-at-start and short glitch rejected, release and re-press accepted.
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 8);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0001, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0101, DEB - 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 10);
    checkOne("glitch held none", {1'b0, cntA}, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 10);
    checkOne("repress counted", {1'b0, cntA}, 4'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 1);
    checkOne("repress votes", votesA, 4'b0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 8);

    // Reset in the middle of a session.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0010, 10);
    btn = 4'b0000;
    checkOne("prereset cnt", {1'b0, cntA}, 4'd1);
    doReset();
    checkOne("reset votes", votesA, 4'b0000);
    checkOne("reset busy", {3'b000, busyA}, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 6);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1);
    checkOne("postreset empty", {1'b0, cntA}, 4'd0);
    checkOne("postreset busy", {3'b000, busyA}, 4'b0001);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000, 1);
    checkOne("postreset votes", votesA, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 2);

    // Double press counts once; a vote on the close edge is kept.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1000, 8);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1000, 8);
    checkOne("double press cnt", {1'b0, cntA}, 4'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0100, DEB + 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0100, 1);
    checkOne("close edge votes", votesA, 4'b1100);
    checkOne("close edge valid", {3'b000, validA}, 4'b0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000, 8);

    // Random traffic, including glitches, stray start/close and occasional resets.
    for (int n = 0; n < 600; n++) begin
      rb = btn;
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) rb[i] = ~rb[i];
      rsA = ($urandom_range(0, 24) == 0);
      rsB = ($urandom_range(0, 24) == 0);
      rc  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) doReset();
      applyStimulus(rsA, rsB, rc, rb, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
